button_irq_ctrl: RTL
====================

BUTTON_IRQ_CTRL -- requirements
Module: button_irq_ctrl

Interface
REQ-001 Parameter PEND_ADDR, default 18'h0FF10, bus address of the pending register (read; write-1-to-clear).
REQ-002 Parameter MASK_ADDR, default 18'h0FF11, bus address of the mask register (read/write).
REQ-003 Parameter DEB_CYCLES, default 3, consecutive equal synchronized samples required to accept a button level; legal range 1..255.
REQ-004 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 oe  input  1  CPU bus direction: 1 = CPU drives data (write), 0 = CPU reads.
REQ-007 addresses  input  18  CPU bus address.
REQ-008 data  inout  16  shared CPU data bus.
REQ-009 buttons  input  4  raw, asynchronous, active-high push buttons.
REQ-010 interruptions_io  output  8  level interrupt requests to the CPU; bits 3:0 = buttons 3:0, bits 7:4 SHALL be tied to 0.

Function
REQ-011 Each buttons[i] SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Each synchronized bit SHALL feed a debouncer: a counter increments while the sample differs from the accepted level and clears when the two are equal; the accepted level SHALL toggle when the counter reaches DEB_CYCLES, and the counter SHALL then clear.
REQ-013 A 0->1 transition of the accepted level of bit i SHALL set pend[i] on the same edge on which the level toggles.
REQ-014 The minimum latency from a clean button rise to pend[i]=1 SHALL be 2 + DEB_CYCLES clock edges; glitches shorter than DEB_CYCLES samples SHALL NOT set pend.
REQ-015 interruptions_io[i] SHALL equal pend[i] AND mask[i] as a registered-state combinational output with no extra delay.
REQ-016 Bus write: when oe=1 on a rising edge and addresses==PEND_ADDR, each pend[i] with data[i]=1 SHALL clear; data bits 15:4 SHALL be ignored.
REQ-017 Bus write: when oe=1 on a rising edge and addresses==MASK_ADDR, mask SHALL load data[3:0].
REQ-018 If a set event (REQ-013) and a clear (REQ-016) hit the same bit in the same cycle, set SHALL win and pend[i] SHALL remain 1.
REQ-019 Bus read: when oe=0 and addresses==PEND_ADDR, data SHALL be driven with {12'b0, pend}; when oe=0 and addresses==MASK_ADDR, data SHALL be driven with {12'b0, mask}; this path SHALL be combinational.
REQ-020 In all other cases, including oe=1, the block SHALL drive data to high impedance.
REQ-021 Mask changes SHALL NOT alter pend; a masked pending bit SHALL assert its interrupt as soon as the mask bit is set.
REQ-022 Writes to any other address SHALL have no effect.

Reset
REQ-023 While reset=0, the following SHALL be cleared asynchronously: synchronizers, debounce counters, accepted levels, pend and interruptions_io.
REQ-024 While reset=0, mask SHALL be set to 4'hF.
REQ-025 Reset asserted mid-debounce SHALL discard the partial count; a button held through the release of reset SHALL generate one pend event after 2 + DEB_CYCLES edges.
REQ-026 data SHALL be high impedance while reset=0.

Structure
REQ-027 The address constants PEND_ADDR and MASK_ADDR and the bit-width constants SHALL live in the shared I/O address include file used by the bus-mapped peripherals.
REQ-028 A sub-module btn_debounce (1 bit: synchronizer, counter and accepted level, with a rise-pulse output) SHALL be instantiated four times.

Verification
REQ-029 Scenario: reset release; buttons=4'b0001 held for 10 cycles -> pend=4'b0001 exactly 5 edges after the rise, and interruptions_io=8'h01.
REQ-030 Scenario: buttons[1] pulse of 2 cycles with DEB_CYCLES=3 -> pend stays 0 and interruptions_io=8'h00.
REQ-031 Scenario: pend=4'b0011; write 16'h0001 to PEND_ADDR -> pend=4'b0010 and interruptions_io=8'h02; a subsequent read of PEND_ADDR returns 16'h0002.
REQ-032 Scenario: write 16'h0000 to MASK_ADDR, then press button 2 -> pend=4'b0100 and interruptions_io=8'h00; write 16'h0004 to MASK_ADDR -> interruptions_io=8'h04 on the next cycle.
REQ-033 Scenario: clear of bit 0 in the same cycle that pend[0] sets -> pend[0]=1.
REQ-034 Scenario: reset=0 asserted mid-debounce, then released with the button held -> exactly one pend event; data is high impedance whenever oe=1 or the address does not match.

Source files
------------

// File: rtl/button_irq_ctrl_pkg.sv
// Shared I/O map and width constants for the bus-mapped button interrupt controller.
package button_irq_ctrl_pkg;

  localparam int ADDR_W    = 18;
  localparam int DATA_W    = 16;
  localparam int BTN_W     = 4;
  localparam int IRQ_W     = 8;
  localparam int DEB_CNT_W = 8;

  localparam logic [ADDR_W-1:0] PEND_ADDR_DEFAULT = 18'h0FF10;
  localparam logic [ADDR_W-1:0] MASK_ADDR_DEFAULT = 18'h0FF11;
  localparam logic [BTN_W-1:0]  MASK_RESET        = '1;

  // Registers are narrower than the bus; readback zero-fills the upper bits.
  function automatic logic [DATA_W-1:0] zext_reg(input logic [BTN_W-1:0] r);
    return {{(DATA_W-BTN_W){1'b0}}, r};
  endfunction

endpackage

// File: rtl/button_irq_ctrl_debounce.sv
// One button lane: 2-flop synchronizer, debounce counter and accepted level.
// rise_o is combinational so the caller can latch it on the same edge the level toggles.
module btn_debounce
  import button_irq_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic rise_o
);

  localparam logic [DEB_CNT_W-1:0] DEB_LIMIT = DEB_CNT_W'(DEB_CYCLES);

  logic                 sync1_q, sync2_q;
  logic                 level_q, level_d;
  logic [DEB_CNT_W-1:0] cnt_q, cnt_d;
  logic                 differ, reached;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  always_comb begin
    differ  = (sync2_q != level_q);
    reached = differ && ((cnt_q + 1'b1) == DEB_LIMIT);
    cnt_d   = '0;
    level_d = level_q;
    if (reached) begin
      level_d = ~level_q;
    end else if (differ) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign rise_o = reached && !level_q;

endmodule

// File: rtl/button_irq_ctrl.sv
// Four debounced buttons feeding a pending register (W1C) and a mask register,
// both mapped on the shared CPU bus; level interrupts are pend AND mask.
module button_irq_ctrl
  import button_irq_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PEND_ADDR  = PEND_ADDR_DEFAULT,
  parameter logic [ADDR_W-1:0] MASK_ADDR  = MASK_ADDR_DEFAULT,
  parameter int                DEB_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              oe,
  input  logic [ADDR_W-1:0] addresses,
  inout  wire  [DATA_W-1:0] data,
  input  logic [BTN_W-1:0]  buttons,
  output logic [IRQ_W-1:0]  interruptions_io
);

  logic [BTN_W-1:0]  pend_q, pend_d;
  logic [BTN_W-1:0]  mask_q, mask_d;
  logic [BTN_W-1:0]  riseBits;
  logic [BTN_W-1:0]  clearBits;
  logic              writePend, writeMask;
  logic              readEn;
  logic [DATA_W-1:0] readVal;
  logic              unusedDataHi;

  for (genvar i = 0; i < BTN_W; i++) begin : gLane
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) uDeb (
      .clk   (clk),
      .reset (reset),
      .btn_i (buttons[i]),
      .rise_o(riseBits[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q <= '0;
      mask_q <= MASK_RESET;
    end else begin
      pend_q <= pend_d;
      mask_q <= mask_d;
    end
  end

  // A rise on the same edge as a W1C clear must win, so OR the set in last.
  always_comb begin
    writePend = oe && (addresses == PEND_ADDR);
    writeMask = oe && (addresses == MASK_ADDR);
    clearBits = writePend ? data[BTN_W-1:0] : '0;
    pend_d    = (pend_q & ~clearBits) | riseBits;
    mask_d    = writeMask ? data[BTN_W-1:0] : mask_q;
  end

  always_comb begin
    readEn  = 1'b0;
    readVal = '0;
    if (reset && !oe) begin
      if (addresses == PEND_ADDR) begin
        readEn  = 1'b1;
        readVal = zext_reg(pend_q);
      end else if (addresses == MASK_ADDR) begin
        readEn  = 1'b1;
        readVal = zext_reg(mask_q);
      end
    end
  end

  assign data             = readEn ? readVal : {DATA_W{1'bz}};
  assign interruptions_io = {{(IRQ_W-BTN_W){1'b0}}, pend_q & mask_q};
  assign unusedDataHi     = ^data[DATA_W-1:BTN_W];

endmodule
